bp_fe_bht_updater: RTL

In-order update engine sitting between the front-end branch predictor and the branch history table. It records each issued BHT prediction (index plus predicted direction) in a small FIFO. When the backend resolves branches in program order, it retires the oldest entry and drives a one-cycle registered write to the BHT: write-valid, index, and a `correct` flag. A flush discards all outstanding predictions.

---
 rtl/bp_fe_bht_updater.sv | 113 +++++++++++
 1 files changed

// File: rtl/bp_fe_bht_updater.sv
// In-order BHT update engine: queues issued predictions and retires them on resolve.
// Optional mispredict statistics counter enabled by BP_FE_BHT_UPDATER_STATS_EN.
module bp_fe_bht_updater #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned depth_p         = 8,
  localparam int unsigned ptr_width_lp   = $clog2(depth_p),
  localparam int unsigned count_width_lp = $clog2(depth_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_v_i,
  input  logic [bht_idx_width_p-1:0] enq_idx_i,
  input  logic                       enq_pred_i,
  output logic                       enq_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [count_width_lp-1:0]  count_o,
  output logic [15:0]                mispredict_cnt_o
);

  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(depth_p);

  logic [bht_idx_width_p:0]       mem [depth_p];
  logic [ptr_width_lp-1:0]        wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]        rptr_q, rptr_d;
  logic [count_width_lp-1:0]      count_q, count_d;
  logic                           w_v_q;
  logic [bht_idx_width_p-1:0]     idx_w_q;
  logic                           correct_q;
  logic                           enq_hs, res_hs;
  logic [bht_idx_width_p:0]       rd_entry;

  assign enq_ready_o = (count_q != full_count_lp);
  assign res_ready_o = (count_q != '0);
  assign count_o     = count_q;

  // Flush overrides both handshakes in the same cycle.
  assign enq_hs   = enq_v_i & enq_ready_o & ~flush_i;
  assign res_hs   = res_v_i & res_ready_o & ~flush_i;
  assign rd_entry = mem[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq_hs) wptr_d = wptr_q + ptr_width_lp'(1);
      if (res_hs) rptr_d = rptr_q + ptr_width_lp'(1);
      unique case ({enq_hs, res_hs})
        2'b10:   count_d = count_q + count_width_lp'(1);
        2'b01:   count_d = count_q - count_width_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      w_v_q   <= res_hs;
      if (res_hs) begin
        idx_w_q   <= rd_entry[bht_idx_width_p:1];
        correct_q <= (rd_entry[0] == res_taken_i);
      end
    end
  end

  // Storage deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (enq_hs) mem[wptr_q] <= {enq_idx_i, enq_pred_i};
  end

  assign w_v_o     = w_v_q;
  assign idx_w_o   = idx_w_q;
  assign correct_o = correct_q;

`ifdef BP_FE_BHT_UPDATER_STATS_EN
  logic [15:0] misp_q, misp_d;

  always_comb begin
    misp_d = misp_q;
    if (w_v_q && !correct_q && (misp_q != 16'hFFFF)) misp_d = misp_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) misp_q <= '0;
    else            misp_q <= misp_d;
  end

  assign mispredict_cnt_o = misp_q;
`else
  assign mispredict_cnt_o = '0;
`endif

endmodule
